// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin bounded-burst arbiter sharing one FIFO write port among N_REQ requesters
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 32,
  parameter int MAX_BURST = 8,
  localparam int PW = $clog2(N_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      fifo_full,
  output logic                      fifo_w_en,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic [CW-1:0]             burst_cnt
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [PW-1:0] rr_ptr, own, sel, idx;
  logic owner_req, last;
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      idx = PW'((int'(rr_ptr) + j) % N_REQ);
      if (req[idx]) sel = idx;
    end
  end
  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) fifo_data = fifo_data | ({DATA_W{grant[i]}} & req_data[i*DATA_W +: DATA_W]);
  end
  assign owner_req = |(grant & req);
  assign fifo_w_en = owner_req & ~fifo_full;
  assign ack = grant & {N_REQ{fifo_w_en}};
  assign busy = state == BURST;
  assign last = fifo_w_en && burst_cnt == CW'(MAX_BURST - 1);
  // grant is cleared asynchronously so a reset mid-burst kills the write in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
      own <= '0;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state <= BURST;
        grant <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
        own <= sel;
        burst_cnt <= '0;
      end
    end else if (!owner_req || last) begin
      state <= IDLE;
      grant <= '0;
      burst_cnt <= '0;
      rr_ptr <= own == PW'(N_REQ - 1) ? '0 : own + 1'b1;
    end else if (fifo_w_en) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one 32-bit synchronous FIFO write port among N_REQ requesters. Each requester presents a word with a valid/ack handshake. The arbiter grants one requester at a time for a bounded burst and drives the FIFO's write enable and data, honouring the FIFO's full flag. It sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
- N_REQ, 4: number of requesters, 2..8
- DATA_W, 32: word width; matches the FIFO data_in
- MAX_BURST, 8: maximum words written per grant, ≥1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester valid; requester holds it and its data stable until ack
- req_data  in  N_REQ*DATA_W  requester i word on bits [i*DATA_W +: DATA_W]
- fifo_full  in  1  full flag from the FIFO
- fifo_w_en  out  1  FIFO write enable
- fifo_data  out  DATA_W  FIFO write data
- ack  out  N_REQ  one-hot pulse: requester i's word written this cycle
- grant  out  N_REQ  registered one-hot current owner; all-zero when idle
- busy  out  1  high in BURST state
- burst_cnt  out  clog2(MAX_BURST+1)  words written in the current burst

## Operation
- Reset values: state IDLE, grant 0, rr_ptr 0, burst_cnt 0. Outputs fifo_w_en, ack and busy are 0; fifo_data is 0.
- Two-state FSM: IDLE, BURST.
- IDLE, when any req is high:
  - Select the first set req[k], searching k = rr_ptr, rr_ptr+1, … mod N_REQ.
  - Next edge: grant ← onehot(k), burst_cnt ← 0, state ← BURST.
  - No write occurs in the IDLE cycle.
- BURST, owner g:
  - Combinational outputs: fifo_w_en = req[g] & ~fifo_full; fifo_data = req_data[g]; ack = grant & {N_REQ{fifo_w_en}}.
  - fifo_data equals the owner's word whenever in BURST; it is 0 in IDLE.
  - On each write, burst_cnt increments.
- Burst termination (whichever first):
  - req[g] low at a clock edge.
  - Write of the MAX_BURST-th word.
- On termination, next edge: state ← IDLE, grant ← 0, rr_ptr ← (g+1) mod N_REQ, burst_cnt ← 0.
- fifo_full high stalls the burst:
  - No write, no ack, burst_cnt held.
  - State stays BURST while req[g] is high. There is no timeout.
  - Never write while fifo_full = 1; overflow protection is the arbiter's job.
- Non-owner req lines are ignored during BURST. Their data must be held until granted.
- A requester that drops req without ack forfeits nothing except its turn.
- rr_ptr wraps from N_REQ-1 to 0.

## Timing
- Grant latency: req rises in IDLE at edge t → grant at t+1 → first fifo_w_en in cycle t+1 (if not full).
- Steady state is one word per cycle while req[g]=1 and fifo_full=0. A MAX_BURST burst occupies MAX_BURST+1 cycles including the IDLE arbitration cycle.
- fifo_full is sampled combinationally in the same cycle as the write. The FIFO updates full at the edge that commits the write.
- Reset mid-burst: grant clears immediately (asynchronous), so fifo_w_en and ack drop in the same cycle. No partial write is committed at the next edge. rr_ptr returns to 0.
- Simultaneous requests in IDLE: only the round-robin winner is granted. The others wait at least one full burst plus one IDLE cycle.

## Test plan
- Single requester: req[2]=1 with 3 words, then drop. Required: grant=0100 one cycle after req; ack[2] pulses on 3 consecutive cycles; fifo_w_en 3 cycles; FIFO holds the 3 words in order; rr_ptr=3.
- Burst cap: req[0] held with 12 words, MAX_BURST=8. Required: 8 acks; IDLE for 1 cycle; requester 0 re-granted (no other req) and writes the remaining 4.
- Round-robin fairness: all 4 req held continuously, each with unlimited words. Required: grant sequence 0001,0010,0100,1000,0001; each burst exactly 8 writes.
- Full stall: owner 1 mid-burst, fifo_full=1 for 5 cycles. Required: fifo_w_en=0 and ack=0 for 5 cycles; burst_cnt frozen at its value (e.g. 3); resumes at 4 when full drops.
- FIFO fill: write 1024 words from requester 3 with the FIFO read side idle. Required: the 1024th write sets full; no further fifo_w_en until a read occurs.
- Async reset: assert rst mid-cycle during a burst with burst_cnt=5. Required: grant, busy and fifo_w_en go 0 before the next edge. After release, the first request from requester 0 wins over requester 2.
